// File: rtl/tlb_op_ctrl.sv
// Sequencer for the MIPS TLBP/TLBR/TLBWI/TLBWR instructions: stalls the pipeline,
// drives the TLB search/read/write ports, writes CP0 back and maintains CP0 Random.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [1:0]      op_type,
    output logic            op_ready,
    output logic            op_done,
    output logic            stall_o,
    output logic            flush_o,
    input  logic [31:0]     c0_index,
    input  logic [31:0]     c0_wired,
    input  logic            wired_we,
    output logic [31:0]     random_o,
    output logic            tlb_s_req,
    input  logic            tlb_s_found,
    input  logic [IDXW-1:0] tlb_s_index,
    output logic            tlb_r_req,
    output logic [IDXW-1:0] tlb_r_index,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic            cp0_index_we,
    output logic [31:0]     cp0_index_wdata,
    output logic            cp0_tlbr_we
);

    typedef enum logic [2:0] {
        IDLE, PROBE, PWB, READ, RWB, WRITE, FLUSH
    } state_t;

    localparam logic [1:0]      OP_TLBP  = 2'b00;
    localparam logic [1:0]      OP_TLBR  = 2'b01;
    localparam logic [1:0]      OP_TLBWR = 2'b11;
    localparam logic [IDXW-1:0] RND_MAX  = IDXW'(TLBNUM - 1);

    state_t          state;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] rnd;
    logic [IDXW-1:0] wired;
    logic            unused_hi_bits;

    assign wired          = c0_wired[IDXW-1:0];
    assign unused_hi_bits = ^{c0_index[31:IDXW], c0_wired[31:IDXW]};

    assign op_ready    = (state == IDLE);
    assign stall_o     = (state != IDLE) || op_valid;
    assign tlb_r_index = idx;
    assign tlb_w_index = idx;
    assign random_o    = 32'(rnd);

    // Probe result is only meaningful in PWB, where the TLB presents found/index.
    always_comb begin
        cp0_index_wdata = 32'h0;
        if (state == PWB)
            cp0_index_wdata = tlb_s_found ? 32'(tlb_s_index) : 32'h8000_0000;
    end

    // Strobes are registered alongside the state, so each is high exactly in its state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            op_done      <= 1'b0;
            flush_o      <= 1'b0;
            tlb_s_req    <= 1'b0;
            tlb_r_req    <= 1'b0;
            tlb_we       <= 1'b0;
            cp0_index_we <= 1'b0;
            cp0_tlbr_we  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; a default-low here lets each state raise only its own strobe.
            op_done      <= 1'b0;
            flush_o      <= 1'b0;
            tlb_s_req    <= 1'b0;
            tlb_r_req    <= 1'b0;
            tlb_we       <= 1'b0;
            cp0_index_we <= 1'b0;
            cp0_tlbr_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        idx <= (op_type == OP_TLBWR) ? rnd : c0_index[IDXW-1:0];
                        case (op_type)
                            OP_TLBP: begin
                                state     <= PROBE;
                                tlb_s_req <= 1'b1;
                            end
                            OP_TLBR: begin
                                state     <= READ;
                                tlb_r_req <= 1'b1;
                            end
                            default: begin
                                state  <= WRITE;
                                tlb_we <= 1'b1;
                            end
                        endcase
                    end
                end
                PROBE: begin
                    state        <= PWB;
                    cp0_index_we <= 1'b1;
                    op_done      <= 1'b1;
                end
                READ: begin
                    state       <= RWB;
                    cp0_tlbr_we <= 1'b1;
                    op_done     <= 1'b1;
                end
                WRITE: begin
                    state   <= FLUSH;
                    flush_o <= 1'b1;
                    op_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Random wraps to the top once it reaches Wired; using <= also recovers if Wired moves above it.
    always_ff @(posedge clk) begin
        if (rst || wired_we || (wired >= RND_MAX) || (rnd <= wired))
            rnd <= RND_MAX;
        else
            rnd <= rnd - 1'b1;
    end

endmodule
